my_mem_arbiter: RTL and testbench

Round-robin controller that shares the single-port parity memory (`my_memhw6`) between `NUM_REQ` requesters. It accepts one read or write at a time, sequences the memory's `write`/`read` strobes, and returns read data to the owning requester. It checks the stored parity bit on every read and keeps a saturating parity-error count. It sits between the requester agents and the memory's master-side interface; it is the only driver of the memory's strobes.

---
 rtl/my_mem_pkg.sv | 30 +++
 rtl/my_mem_arbiter_if.sv | 39 +++
 rtl/my_mem_rr_arb.sv | 29 ++
 rtl/my_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_my_mem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/my_mem_pkg.sv
// Shared types, default widths and the parity helper for the parity-memory arbiter.
package my_mem_pkg;

    localparam int unsigned DEF_NUM_REQ = 2;
    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_DATA_W  = 8;
    localparam int unsigned ERR_W       = 16;
    localparam int unsigned PAR_MAX_W   = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Word is {parity, data}; data occupies bits [data_w-1:0], parity sits at bit data_w.
    function automatic logic parity_ok(input logic [PAR_MAX_W-1:0] word,
                                       input int unsigned          data_w);
        logic p;
        p = 1'b0;
        for (int unsigned b = 0; b < PAR_MAX_W - 1; b++) begin
            if (b < data_w) begin
                p = p ^ word[6'(b)];
            end
        end
        return p == word[6'(data_w)];
    endfunction

endpackage

// File: rtl/my_mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view.
interface my_mem_arbiter_if
    import my_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;

    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_parity_err;
    logic [ERR_W-1:0]          err_count;

    logic                      mem_write;
    logic                      mem_read;
    logic [ADDR_W-1:0]         mem_address;
    logic [DATA_W-1:0]         mem_data_in;
    logic [DATA_W:0]           mem_data_out;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_parity_err, err_count,
               mem_write, mem_read, mem_address, mem_data_in
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_parity_err, err_count,
               mem_write, mem_read, mem_address, mem_data_in
    );

endinterface

// File: rtl/my_mem_rr_arb.sv
// Combinational round-robin picker: search starts one past the last winner.
module my_mem_rr_arb #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin : pick
        int unsigned cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last) + k) % NUM_REQ;
            if (!any && req[IDX_W'(cand)]) begin
                any                 = 1'b1;
                idx                 = IDX_W'(cand);
                grant[IDX_W'(cand)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/my_mem_arbiter.sv
// Round-robin arbiter sharing one single-port parity memory between NUM_REQ requesters.
// One transaction in flight; read parity is checked and mismatches are counted.
module my_mem_arbiter
    import my_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input logic             clk,
    input logic             rst,
    my_mem_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic               wr_q, wr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               mem_write_q, mem_write_d;
    logic               mem_read_q, mem_read_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               perr_q, perr_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;
    logic               sel_write;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;

    my_mem_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arb (
        .req   (bus.req_valid),
        .last  (last_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (any_req)
    );

    // Fields of the requester currently winning the pick.
    always_comb begin : sel_mux
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win_idx) begin
                sel_write = bus.req_write[i];
                sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin : fsm_next
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        rsp_valid_d = '0;
        rdata_d     = '0;
        perr_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = ISSUE;
                    last_d      = win_idx;
                    id_d        = win_idx;
                    wr_d        = sel_write;
                    addr_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    mem_write_d = sel_write;
                    mem_read_d  = !sel_write;
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_d            = RESP;
                    rsp_valid_d[id_q]  = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                state_d           = RESP;
                rsp_valid_d[id_q] = 1'b1;
                rdata_d           = bus.mem_data_out[DATA_W-1:0];
                perr_d            = !parity_ok(PAR_MAX_W'(bus.mem_data_out), DATA_W);
            end
            RESP: begin
                state_d = IDLE;
                if (perr_q && (err_q != {ERR_W{1'b1}})) begin
                    err_d = err_q + ERR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin : fsm_reg
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            id_q        <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            perr_q      <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            id_q        <= id_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            perr_q      <= perr_d;
            err_q       <= err_d;
        end
    end

    // Accept is combinational so the requester sees it in the same cycle it wins.
    assign bus.req_ready      = (!rst && (state_q == IDLE)) ? grant : '0;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_rdata      = rdata_q;
    assign bus.rsp_parity_err = perr_q;
    assign bus.err_count      = err_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_data_in    = wdata_q;

endmodule

// File: tb/tb_my_mem_arbiter.sv
// Directed and random checks of my_mem_arbiter against a parity memory model and scoreboard.
module tb_my_mem_arbiter;
    import my_mem_pkg::*;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;

    logic clk;
    logic rst;

    my_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    my_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic          drv_valid [NR];
    logic          drv_write [NR];
    logic [AW-1:0] drv_addr  [NR];
    logic [DW-1:0] drv_wdata [NR];

    logic          inj_en;
    logic [AW-1:0] inj_addr;
    logic [DW:0]   inj_word;
    logic [DW:0]   mem_arr [256];

    logic          mon_en;
    int            n_acc;
    int            n_rsp;
    logic [DW-1:0] ref_mem [16];
    int            q_id [$];
    logic [DW-1:0] q_dat [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NR; g++) begin : g_pack
        assign bus.req_valid[g]           = drv_valid[g];
        assign bus.req_write[g]           = drv_write[g];
        assign bus.req_addr[g*AW +: AW]   = drv_addr[g];
        assign bus.req_wdata[g*DW +: DW]  = drv_wdata[g];
    end

    // Synchronous memory: parity appended on write, word returned the cycle after the read strobe.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
            bus.mem_data_out <= '0;
        end else begin
            if (bus.mem_write)
                mem_arr[bus.mem_address[7:0]] <= {^bus.mem_data_in, bus.mem_data_in};
            if (bus.mem_read)
                bus.mem_data_out <= (inj_en && bus.mem_address == inj_addr) ?
                                    inj_word : mem_arr[bus.mem_address[7:0]];
        end
    end

    // Scoreboard for random traffic: accepts are serialized, so accept order is memory order.
    always @(negedge clk) begin : sb
        int            id;
        int            eid;
        logic [3:0]    a;
        logic [DW-1:0] ed;
        if (mon_en) begin
            chk("strobe_excl", 32'(bus.mem_write & bus.mem_read), 0);
            if (bus.req_ready != '0) begin
                id = bus.req_ready[1] ? 1 : 0;
                chk("ready_onehot", $countones(bus.req_ready), 1);
                chk("ready_valid", 32'(bus.req_valid[id]), 1);
                n_acc++;
                a = drv_addr[id][3:0];
                if (drv_write[id]) begin
                    ref_mem[a] = drv_wdata[id];
                    q_dat.push_back('0);
                end else begin
                    q_dat.push_back(ref_mem[a]);
                end
                q_id.push_back(id);
            end
            if (bus.rsp_valid != '0) begin
                n_rsp++;
                if (q_id.size() == 0) begin
                    chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
                end else begin
                    eid = q_id.pop_front();
                    ed  = q_dat.pop_front();
                    chk("rsp_id", 32'(bus.rsp_valid), 32'(1) << eid);
                    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(ed));
                    chk("rsp_perr", 32'(bus.rsp_parity_err), 0);
                end
            end
        end
    end

    task automatic run_xact(input int id, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [DW-1:0] exp_rd,
                            input bit exp_pe);
        bit got;
        logic [NR-1:0] oh;
        oh = NR'(1 << id);
        @(posedge clk); #1;
        drv_write[id] = wr;
        drv_addr[id]  = a;
        drv_wdata[id] = d;
        drv_valid[id] = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            got = bus.req_ready[id];
        end
        chk("accept", 32'(got), 1);
        chk("strobe_before", 32'({bus.mem_write, bus.mem_read}), 0);
        @(posedge clk); #1;
        drv_valid[id] = 1'b0;
        @(negedge clk);
        chk("strobe", 32'({bus.mem_write, bus.mem_read}), wr ? 32'h2 : 32'h1);
        chk("mem_address", 32'(bus.mem_address), 32'(a));
        if (wr) chk("mem_data_in", 32'(bus.mem_data_in), 32'(d));
        @(negedge clk);
        chk("strobe_once", 32'({bus.mem_write, bus.mem_read}), 0);
        if (!wr) begin
            chk("wait_no_rsp", 32'(bus.rsp_valid), 0);
            @(negedge clk);
        end
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        chk("rsp_perr", 32'(bus.rsp_parity_err), 32'(exp_pe));
        @(negedge clk);
        chk("rsp_pulse", 32'(bus.rsp_valid), 0);
    endtask

    task automatic rand_drv(input int id);
        for (int n = 0; n < 250; n++) begin
            bit got;
            @(posedge clk);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            drv_write[id] = 1'($urandom_range(0, 1));
            drv_addr[id]  = 16'h0100 | 16'($urandom_range(0, 15));
            drv_wdata[id] = 8'($urandom);
            drv_valid[id] = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 100 && !got; w++) begin
                @(negedge clk);
                got = bus.req_ready[id];
            end
            chk("drv_accept", 32'(got), 1);
            @(posedge clk); #1;
            drv_valid[id] = 1'b0;
        end
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        chk({tag, "_rdata"}, 32'(bus.rsp_rdata), 0);
        chk({tag, "_perr"}, 32'(bus.rsp_parity_err), 0);
        chk({tag, "_err_count"}, 32'(bus.err_count), 0);
        chk({tag, "_strobes"}, 32'({bus.mem_write, bus.mem_read}), 0);
        chk({tag, "_mem_address"}, 32'(bus.mem_address), 0);
        chk({tag, "_mem_data_in"}, 32'(bus.mem_data_in), 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit            got;
        int            n;
        logic [15:0]   exp_err;

        rst      = 1'b1;
        inj_en   = 1'b0;
        inj_addr = 16'h0010;
        inj_word = 9'h100;
        mon_en   = 1'b0;
        n_acc    = 0;
        n_rsp    = 0;
        for (int i = 0; i < NR; i++) begin
            drv_valid[i] = 1'b0;
            drv_write[i] = 1'b0;
            drv_addr[i]  = '0;
            drv_wdata[i] = '0;
        end
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        // Reset state, with a request pending that must not be accepted.
        drv_valid[0] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_values("rst");
        drv_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single write then read back.
        run_xact(0, 1'b1, 16'h1234, 8'hA5, 8'h00, 1'b0);
        run_xact(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 1'b0);

        // Parity error, then a correct word.
        inj_en   = 1'b1;
        inj_word = 9'h100;
        run_xact(1, 1'b0, 16'h0010, 8'h00, 8'h00, 1'b1);
        chk("err_count_inc", 32'(bus.err_count), 1);
        inj_word = 9'h101;
        run_xact(1, 1'b0, 16'h0010, 8'h00, 8'h01, 1'b0);
        chk("err_count_hold", 32'(bus.err_count), 1);

        // Saturation: preload near the top, then five more errors.
        @(posedge clk); #1;
        force dut.err_q = 16'hFFFC;
        @(posedge clk); #1;
        release dut.err_q;
        @(negedge clk);
        chk("err_preload", 32'(bus.err_count), 32'h0000_FFFC);
        inj_word = 9'h100;
        exp_err  = 16'hFFFC;
        for (int k = 0; k < 5; k++) begin
            run_xact(1, 1'b0, 16'h0010, 8'h00, 8'h00, 1'b1);
            exp_err = (exp_err == 16'hFFFF) ? 16'hFFFF : exp_err + 16'd1;
            chk("err_sat", 32'(bus.err_count), 32'(exp_err));
        end
        inj_en = 1'b0;

        // Reset while a read is in WAIT.
        @(posedge clk); #1;
        drv_write[0] = 1'b0;
        drv_addr[0]  = 16'h1234;
        drv_valid[0] = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            @(negedge clk);
            got = bus.req_ready[0];
        end
        chk("mid_accept", 32'(got), 1);
        @(posedge clk); #1;
        drv_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_wait_no_rsp", 32'(bus.rsp_valid), 0);
        @(posedge clk); #1;
        drv_write[0] = 1'b0;
        drv_write[1] = 1'b0;
        drv_addr[0]  = 16'h0300;
        drv_addr[1]  = 16'h0301;
        drv_valid[0] = 1'b1;
        drv_valid[1] = 1'b1;
        @(negedge clk);
        reset_values("mid_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp", 32'(bus.rsp_valid), 0);
        chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        drv_valid[0] = 1'b0;
        drv_valid[1] = 1'b0;
        repeat (6) @(posedge clk);

        // Round-robin fairness with both requesters holding reads.
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drv_write[0] = 1'b0;
        drv_write[1] = 1'b0;
        drv_addr[0]  = 16'h0200;
        drv_addr[1]  = 16'h0201;
        drv_valid[0] = 1'b1;
        drv_valid[1] = 1'b1;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (bus.req_ready != '0) begin
                chk("rr_grant", 32'(bus.req_ready), (n % 2 == 0) ? 32'h1 : 32'h2);
                n++;
            end
        end
        chk("rr_count", 32'(n), 4);
        @(posedge clk); #1;
        drv_valid[0] = 1'b0;
        drv_valid[1] = 1'b0;
        repeat (6) @(posedge clk);

        // Random mixed traffic through the scoreboard.
        mon_en = 1'b1;
        fork
            rand_drv(0);
            rand_drv(1);
        join
        repeat (10) @(posedge clk);
        mon_en = 1'b0;
        chk("sb_accepts", 32'(n_acc), 500);
        chk("sb_responses", 32'(n_rsp), 500);
        chk("sb_drain", 32'(q_id.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
